// File: rtl/multi_alarm_timekeeper.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : multi_alarm_timekeeper                                        |
// | Description : 24 h BCD clock with N programmable alarms and a timed buzzer. |
// |               Optional snooze support is built when ALARM_SNOOZE_EN is      |
// |               defined.                                                      |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module multi_alarm_timekeeper #(
   parameter int CLK_HZ      = 12000000,
   parameter int N_ALARMS    = 4,
   parameter int RING_SECS   = 10,
   parameter int SNOOZE_SECS = 300,
   localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                set_time_we,
   input  logic [23:0]         set_time,
   input  logic                alarm_we,
   input  logic [AW-1:0]       alarm_sel,
   input  logic [23:0]         alarm_time,
   input  logic                alarm_en_in,
   input  logic                stop,
   input  logic                snooze,
   output logic [23:0]         time_bcd,
   output logic                sec_tick,
   output logic                buzzer,
   output logic [N_ALARMS-1:0] alarm_hit
);

   localparam int PW = $clog2(CLK_HZ);
   localparam logic [PW-1:0] C_PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [7:0]    C_RING      = RING_SECS[7:0];

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RINGING = 2'd1;
`ifdef ALARM_SNOOZE_EN
   localparam logic [1:0] ST_SNOOZED = 2'd2;
   localparam logic [15:0] C_SNOOZE  = SNOOZE_SECS[15:0];
`endif

   function automatic logic bcd_valid(input logic [23:0] t);
      bcd_valid = (t[23:20] <= 4'd2) && (t[19:16] <= 4'd9) &&
                  !((t[23:20] == 4'd2) && (t[19:16] > 4'd3)) &&
                  (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
                  (t[7:4]   <= 4'd5) && (t[3:0]  <= 4'd9);
   endfunction

   // Ripple the carry digit by digit; hours wrap as a pair at 23.
   function automatic logic [23:0] bcd_inc(input logic [23:0] t);
      logic [3:0] ht, ho, mt, mo, st, so;
      {ht, ho, mt, mo, st, so} = t;
      if (so != 4'd9) so = so + 4'd1;
      else begin
         so = 4'd0;
         if (st != 4'd5) st = st + 4'd1;
         else begin
            st = 4'd0;
            if (mo != 4'd9) mo = mo + 4'd1;
            else begin
               mo = 4'd0;
               if (mt != 4'd5) mt = mt + 4'd1;
               else begin
                  mt = 4'd0;
                  if (ht == 4'd2 && ho == 4'd3) begin
                     ht = 4'd0;
                     ho = 4'd0;
                  end else if (ho == 4'd9) begin
                     ho = 4'd0;
                     ht = ht + 4'd1;
                  end else begin
                     ho = ho + 4'd1;
                  end
               end
            end
         end
      end
      bcd_inc = {ht, ho, mt, mo, st, so};
   endfunction

   logic [PW-1:0]       presc_q, presc_d;
   logic [23:0]         time_q, time_d;
   logic                sec_tick_q, sec_tick_d;
   logic                buzzer_q, buzzer_d;
   logic [N_ALARMS-1:0] hit_q, hit_d;
   logic [1:0]          state_q, state_d;
   logic [7:0]          ring_cnt_q, ring_cnt_d;
   logic [23:0]         alarm_time_q [N_ALARMS];
   logic [23:0]         alarm_time_d [N_ALARMS];
   logic [N_ALARMS-1:0] alarm_en_q, alarm_en_d;

   logic                w_set;
   logic                w_tick;
   logic                w_alarm_wr;
   logic [23:0]         w_time_next;
   logic [N_ALARMS-1:0] w_match;
   logic                w_any_match;

   assign w_set       = set_time_we && bcd_valid(set_time);
   assign w_tick      = !w_set && (presc_q == C_PRESC_MAX);
   assign w_time_next = bcd_inc(time_q);
   assign w_alarm_wr  = alarm_we && (32'(alarm_sel) < N_ALARMS) && bcd_valid(alarm_time);
   assign w_any_match = |w_match;

   genvar gi;
   generate
      for (gi = 0; gi < N_ALARMS; gi++) begin : g_match
         assign w_match[gi] = w_tick && alarm_en_q[gi] && (alarm_time_q[gi] == w_time_next);
      end
   endgenerate

   always_comb begin
      presc_d    = (w_set || w_tick) ? '0 : presc_q + PW'(1);
      time_d     = w_set ? set_time : (w_tick ? w_time_next : time_q);
      sec_tick_d = w_tick;
      alarm_time_d = alarm_time_q;
      alarm_en_d   = alarm_en_q;
      for (int i = 0; i < N_ALARMS; i++) begin
         if (w_alarm_wr && (alarm_sel == AW'(i))) begin
            alarm_time_d[i] = alarm_time;
            alarm_en_d[i]   = alarm_en_in;
         end
      end
   end

`ifdef ALARM_SNOOZE_EN
   logic [15:0] snz_cnt_q, snz_cnt_d;
`else
   logic unused_snooze;
   assign unused_snooze = snooze ^ (SNOOZE_SECS != 0);
`endif

   // A match always wins, even over a coincident stop; stop wins over snooze.
   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      hit_d      = hit_q;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_d  = snz_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_any_match) begin
               state_d    = ST_RINGING;
               ring_cnt_d = C_RING;
               hit_d      = w_match;
            end
         end
         ST_RINGING: begin
            if (w_any_match) begin
               ring_cnt_d = C_RING;
               hit_d      = stop ? w_match : (hit_q | w_match);
            end else if (stop) begin
               state_d = ST_IDLE;
               hit_d   = '0;
`ifdef ALARM_SNOOZE_EN
            end else if (snooze) begin
               state_d   = ST_SNOOZED;
               snz_cnt_d = C_SNOOZE;
`endif
            end else if (w_tick) begin
               if (ring_cnt_q == 8'd1) begin
                  state_d = ST_IDLE;
                  hit_d   = '0;
               end
               ring_cnt_d = ring_cnt_q - 8'd1;
            end
         end
`ifdef ALARM_SNOOZE_EN
         ST_SNOOZED: begin
            if (w_any_match) begin
               state_d    = ST_RINGING;
               ring_cnt_d = C_RING;
               hit_d      = stop ? w_match : (hit_q | w_match);
            end else if (stop) begin
               state_d = ST_IDLE;
               hit_d   = '0;
            end else if (w_tick) begin
               if (snz_cnt_q == 16'd1) begin
                  state_d    = ST_RINGING;
                  ring_cnt_d = C_RING;
               end
               snz_cnt_d = snz_cnt_q - 16'd1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            hit_d   = '0;
         end
      endcase
      buzzer_d = (state_d == ST_RINGING);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= '0;
         time_q     <= '0;
         sec_tick_q <= 1'b0;
         buzzer_q   <= 1'b0;
         hit_q      <= '0;
         state_q    <= ST_IDLE;
         ring_cnt_q <= '0;
         alarm_en_q <= '0;
         for (int i = 0; i < N_ALARMS; i++) alarm_time_q[i] <= '0;
      end else begin
         presc_q      <= presc_d;
         time_q       <= time_d;
         sec_tick_q   <= sec_tick_d;
         buzzer_q     <= buzzer_d;
         hit_q        <= hit_d;
         state_q      <= state_d;
         ring_cnt_q   <= ring_cnt_d;
         alarm_en_q   <= alarm_en_d;
         alarm_time_q <= alarm_time_d;
      end
   end

`ifdef ALARM_SNOOZE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) snz_cnt_q <= '0;
      else        snz_cnt_q <= snz_cnt_d;
   end
`endif

   assign time_bcd  = time_q;
   assign sec_tick  = sec_tick_q;
   assign buzzer    = buzzer_q;
   assign alarm_hit = hit_q;

endmodule
`default_nettype wire
